// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-register control codes and hazard controller state encoding.
package pipe_ctrl_pkg;
  localparam logic [1:0] CTRL_PASS  = 2'b00;
  localparam logic [1:0] CTRL_HOLD  = 2'b01;
  localparam logic [1:0] CTRL_FLUSH = 2'b10;

  typedef enum logic {ST_RUN, ST_MEM_WAIT} state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (inc && ~&cnt)     cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch/jump redirect and bounded memory waits,
// with saturating stall/flush counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Jump,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rt,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Req,
  input  logic             Mem_Ready,
  input  logic             Cnt_Clear,
  output logic             PC_Write,
  output logic [1:0]       IF_ID_Ctrl,
  output logic [1:0]       ID_EX_Ctrl,
  output logic [1:0]       EX_MEM_Ctrl,
  output logic [1:0]       MEM_WB_Ctrl,
  output logic             Mem_Timeout,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [WW-1:0]   wait_cnt, wait_nxt;
  logic            release_now, mem_stall, load_use, branch_sel;
  logic            timeout_q, forced;

  assign release_now = (state == ST_MEM_WAIT) && (wait_cnt == WW'(MEM_TIMEOUT - 1));
  assign mem_stall   = MEM_Req && !Mem_Ready && !release_now;
  assign load_use    = EX_MemRead && (EX_Rt != 5'd0) &&
                       ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
  // Only a release that actually cut a pending access short counts as a timeout.
  assign forced      = release_now && MEM_Req && !Mem_Ready;

  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Ctrl  = CTRL_PASS;
    ID_EX_Ctrl  = CTRL_PASS;
    EX_MEM_Ctrl = CTRL_PASS;
    MEM_WB_Ctrl = CTRL_PASS;
    branch_sel  = 1'b0;
    if (!reset) begin
      PC_Write    = 1'b0;
      IF_ID_Ctrl  = CTRL_FLUSH;
      ID_EX_Ctrl  = CTRL_FLUSH;
      EX_MEM_Ctrl = CTRL_FLUSH;
      MEM_WB_Ctrl = CTRL_FLUSH;
    end else if (mem_stall) begin
      PC_Write    = 1'b0;
      IF_ID_Ctrl  = CTRL_HOLD;
      ID_EX_Ctrl  = CTRL_HOLD;
      EX_MEM_Ctrl = CTRL_HOLD;
      MEM_WB_Ctrl = CTRL_FLUSH;
    end else if (EX_BranchTaken) begin
      // Wrong-path ID instruction is squashed, so a load-use hazard there is moot.
      branch_sel  = 1'b1;
      IF_ID_Ctrl  = CTRL_FLUSH;
      ID_EX_Ctrl  = CTRL_FLUSH;
    end else if (load_use) begin
      PC_Write    = 1'b0;
      IF_ID_Ctrl  = CTRL_HOLD;
      ID_EX_Ctrl  = CTRL_FLUSH;
    end else if (ID_Jump) begin
      IF_ID_Ctrl  = CTRL_FLUSH;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = '0;
    case (state)
      ST_RUN:      if (mem_stall) state_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        if (Mem_Ready || release_now) state_nxt = ST_RUN;
        else                          wait_nxt  = wait_cnt + 1'b1;
      end
      default:     state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (forced) timeout_q <= 1'b1;
    end
  end

  // Flag is visible in the release cycle itself, then held by timeout_q.
  assign Mem_Timeout = timeout_q || forced;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(!PC_Write), .clr(Cnt_Clear), .cnt(Stall_Count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(branch_sel), .clr(Cnt_Clear), .cnt(Flush_Count)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with MEM_TIMEOUT=4.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rt;
  logic        ID_UsesRt, ID_Jump, EX_MemRead, EX_BranchTaken, MEM_Req, Mem_Ready, Cnt_Clear;
  logic        PC_Write, Mem_Timeout;
  logic [1:0]  IF_ID_Ctrl, ID_EX_Ctrl, EX_MEM_Ctrl, MEM_WB_Ctrl;
  logic [15:0] Stall_Count, Flush_Count;

  int n_tests = 0;
  int n_fail  = 0;

  // {PC_Write, IF_ID, ID_EX, EX_MEM, MEM_WB}
  localparam logic [8:0] V_PASS  = 9'b1_00_00_00_00;
  localparam logic [8:0] V_RST   = 9'b0_10_10_10_10;
  localparam logic [8:0] V_LU    = 9'b0_01_10_00_00;
  localparam logic [8:0] V_BR    = 9'b1_10_10_00_00;
  localparam logic [8:0] V_JMP   = 9'b1_10_00_00_00;
  localparam logic [8:0] V_MWAIT = 9'b0_01_01_01_10;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
    .EX_BranchTaken(EX_BranchTaken), .MEM_Req(MEM_Req), .Mem_Ready(Mem_Ready),
    .Cnt_Clear(Cnt_Clear), .PC_Write(PC_Write), .IF_ID_Ctrl(IF_ID_Ctrl),
    .ID_EX_Ctrl(ID_EX_Ctrl), .EX_MEM_Ctrl(EX_MEM_Ctrl), .MEM_WB_Ctrl(MEM_WB_Ctrl),
    .Mem_Timeout(Mem_Timeout), .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ctl();
    return {PC_Write, IF_ID_Ctrl, ID_EX_Ctrl, EX_MEM_Ctrl, MEM_WB_Ctrl};
  endfunction

  // Advance to just after the next rising edge; settle combinational outputs.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0; ID_Jump = 1'b0;
    EX_MemRead = 1'b0; EX_Rt = 5'd0; EX_BranchTaken = 1'b0;
    MEM_Req = 1'b0; Mem_Ready = 1'b0; Cnt_Clear = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #1;
    chk("rst_ctl", 32'(ctl()), 32'(V_RST));
    chk("rst_stall", 32'(Stall_Count), 0);
    chk("rst_flush", 32'(Flush_Count), 0);
    chk("rst_tmo", 32'(Mem_Timeout), 0);
    step(); step();
    reset = 1'b1; #1;
    chk("idle_ctl", 32'(ctl()), 32'(V_PASS));

    // load-use on Rs
    EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8; #1;
    chk("lu_rs_ctl", 32'(ctl()), 32'(V_LU));
    step();
    chk("lu_rs_stall", 32'(Stall_Count), 1);
    EX_Rt = 5'd0; ID_Rs = 5'd0; #1;
    chk("lu_r0_ctl", 32'(ctl()), 32'(V_PASS));
    step();
    chk("lu_r0_stall", 32'(Stall_Count), 1);

    // Rt only matters when ID actually reads it
    EX_Rt = 5'd9; ID_Rs = 5'd1; ID_Rt = 5'd9; ID_UsesRt = 1'b0; #1;
    chk("lu_rt_unused", 32'(ctl()), 32'(V_PASS));
    ID_UsesRt = 1'b1; #1;
    chk("lu_rt_used", 32'(ctl()), 32'(V_LU));
    step();
    chk("lu_rt_stall", 32'(Stall_Count), 2);

    // branch overrides the load-use hazard
    EX_BranchTaken = 1'b1; #1;
    chk("br_ctl", 32'(ctl()), 32'(V_BR));
    step();
    chk("br_flush", 32'(Flush_Count), 1);
    chk("br_stall", 32'(Stall_Count), 2);

    idle(); ID_Jump = 1'b1; #1;
    chk("jmp_ctl", 32'(ctl()), 32'(V_JMP));
    step();
    chk("jmp_flush", 32'(Flush_Count), 1);

    // memory wait: 3 frozen cycles, branch during freeze ignored
    idle(); MEM_Req = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      EX_BranchTaken = (i == 1); #1;
      chk($sformatf("mw_ctl%0d", i), 32'(ctl()), 32'(V_MWAIT));
      step();
    end
    EX_BranchTaken = 1'b0;
    chk("mw_stall", 32'(Stall_Count), 5);
    chk("mw_flush", 32'(Flush_Count), 1);
    Mem_Ready = 1'b1; #1;
    chk("mw_done_ctl", 32'(ctl()), 32'(V_PASS));
    step();
    chk("mw_done_stall", 32'(Stall_Count), 5);

    // ready in the first request cycle: no stall
    #1;
    chk("mw_imm_ctl", 32'(ctl()), 32'(V_PASS));
    step();
    chk("mw_imm_stall", 32'(Stall_Count), 5);

    // timeout: 4 frozen cycles, released in the 5th
    Mem_Ready = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_frz%0d", i), 32'(ctl()), 32'(V_MWAIT));
      chk($sformatf("to_flag%0d", i), 32'(Mem_Timeout), 0);
      step();
    end
    chk("to_rel_ctl", 32'(ctl()), 32'(V_PASS));
    chk("to_rel_flag", 32'(Mem_Timeout), 1);
    step();
    MEM_Req = 1'b0; #1;
    chk("to_stall", 32'(Stall_Count), 9);
    step(); step();
    chk("to_sticky", 32'(Mem_Timeout), 1);

    // reset mid-wait, then a fresh full-length wait
    MEM_Req = 1'b1; #1;
    step(); step();
    chk("rmw_frozen", 32'(ctl()), 32'(V_MWAIT));
    #1 reset = 1'b0; #1;
    chk("rmw_ctl", 32'(ctl()), 32'(V_RST));
    chk("rmw_stall", 32'(Stall_Count), 0);
    chk("rmw_flush", 32'(Flush_Count), 0);
    chk("rmw_tmo", 32'(Mem_Timeout), 0);
    step();
    reset = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rmw_frz%0d", i), 32'(ctl()), 32'(V_MWAIT));
      step();
    end
    chk("rmw_rel_ctl", 32'(ctl()), 32'(V_PASS));
    chk("rmw_rel_flag", 32'(Mem_Timeout), 1);
    step();
    idle(); #1;
    chk("rmw_stall4", 32'(Stall_Count), 4);

    // saturation and clear
    EX_MemRead = 1'b1; EX_Rt = 5'd3; ID_Rs = 5'd3;
    for (int i = 0; i < 65540; i++) step();
    chk("sat_stall", 32'(Stall_Count), 32'h0000_FFFF);
    EX_BranchTaken = 1'b1; step();
    chk("sat_flush", 32'(Flush_Count), 1);
    EX_BranchTaken = 1'b0; Cnt_Clear = 1'b1; step();
    chk("clr_stall", 32'(Stall_Count), 0);
    chk("clr_flush", 32'(Flush_Count), 0);
    Cnt_Clear = 1'b0; step();
    chk("clr_resume", 32'(Stall_Count), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Sequences the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC by generating their 2-bit `Control` codes:
  - 00: pass.
  - 01: hold.
  - 10: flush/bubble.
- Detects load-use hazards, taken-branch and jump redirects, and data-memory wait states.
- Bounds memory waits with a timeout and keeps saturating stall/flush performance counters.
- Sits beside the pipeline registers in the top-level CPU. Its outputs drive their `Control` inputs directly.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 16: maximum consecutive frozen cycles for one memory access; legal range ≥2.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `ID_Rs`, `ID_Rt` input 5 each: source registers of the instruction in ID.
- `ID_UsesRt` input 1: instruction in ID reads Rt.
- `ID_Jump` input 1: jump resolved in ID.
- `EX_MemRead` input 1: instruction in EX is a load.
- `EX_Rt` input 5: load destination in EX.
- `EX_BranchTaken` input 1: branch in EX resolved taken.
- `MEM_Req` input 1: load/store present in MEM.
- `Mem_Ready` input 1: data memory completes the access this cycle.
- `Cnt_Clear` input 1: synchronous clear of both counters.
- `PC_Write` output 1: PC update enable.
- `IF_ID_Ctrl`, `ID_EX_Ctrl`, `EX_MEM_Ctrl`, `MEM_WB_Ctrl` output 2 each: register control codes.
- `Mem_Timeout` output 1: sticky flag, set when a wait was forcibly released.
- `Stall_Count` output CNT_W: cycles with PC_Write=0.
- `Flush_Count` output CNT_W: cycles with a branch flush.

## Operation
- States: RUN and MEM_WAIT.
  - `wait_cnt` is cleared in RUN and increments each MEM_WAIT cycle.
  - Width is $clog2(MEM_TIMEOUT+1).
- Derived conditions:
  - `release` = (state==MEM_WAIT && wait_cnt==MEM_TIMEOUT-1).
  - `mem_stall` = MEM_Req && !Mem_Ready && !release.
- Control outputs are a combinational decode of the inputs and state. The first matching priority wins:
  1. `mem_stall`: PC_Write=0; IF_ID=01, ID_EX=01, EX_MEM=01; MEM_WB=10.
  2. `EX_BranchTaken`: PC_Write=1; IF_ID=10, ID_EX=10; EX_MEM=00, MEM_WB=00. Overrides any load-use hazard, because the ID instruction is on the wrong path.
  3. Load-use: EX_MemRead && EX_Rt!=0 && (EX_Rt==ID_Rs || (ID_UsesRt && EX_Rt==ID_Rt)). PC_Write=0; IF_ID=01; ID_EX=10; others 00.
  4. `ID_Jump`: PC_Write=1; IF_ID=10; others 00.
  5. Otherwise: PC_Write=1; all 00.
- State transitions:
  - RUN→MEM_WAIT when `mem_stall`.
  - MEM_WAIT→RUN when Mem_Ready or `release`.
  - MEM_WAIT stays otherwise.
- Freeze length: a wait freezes the pipeline for at most MEM_TIMEOUT cycles, counting the first cycle spent in RUN.
- Timeout release:
  - On the release cycle, Mem_Timeout is set, and stays set until reset.
  - Outputs follow priorities 2–5 as if the access completed.
- Counters (both saturate at all-ones and never wrap):
  - Stall_Count increments on every cycle with PC_Write=0.
  - Flush_Count increments on every cycle where priority 2 is selected.
  - Cnt_Clear has priority over increment; it zeroes both counters in the next cycle.
- Simultaneous events: a branch under `mem_stall` is not acted on. EX holds, so the branch is re-evaluated on the first unfrozen cycle.

## Timing
- Control outputs: zero latency. They are valid in the same cycle as the inputs, which the pipeline registers need.
- Register updates: state, wait_cnt, counters and Mem_Timeout update on the rising edge of clk.
- While reset is low, regardless of the clock:
  - PC_Write=0 and all Ctrl=10.
  - state=RUN, wait_cnt=0, counters=0, Mem_Timeout=0.
- Deasserting reset mid-wait resumes in RUN with a fresh wait count.
- If Mem_Ready is high in the first MEM_Req cycle, no stall occurs and the state stays RUN.

## Structure
- Shared package `pipe_ctrl_pkg`, holding:
  - Ctrl code constants: CTRL_PASS=2'b00, CTRL_HOLD=2'b01, CTRL_FLUSH=2'b10.
  - State encoding: ST_RUN, ST_MEM_WAIT.
- The same package is imported by all pipeline registers.
- Sub-module `sat_counter` (CNT_W-bit, with inc, clr and async active-low reset), instantiated twice.

## Test plan
- Load-use hazard:
  - EX_MemRead=1, EX_Rt=8, ID_Rs=8 → PC_Write=0, IF_ID=01, ID_EX=10; Stall_Count 0→1.
  - Repeat with EX_Rt=0 → all 00, PC_Write=1.
- Branch over load-use: EX_BranchTaken=1 with the same hazard → IF_ID=10, ID_EX=10, PC_Write=1; Flush_Count +1; Stall_Count unchanged.
- Memory wait: MEM_Req=1, Mem_Ready low for 3 cycles then high.
  - Cycles 0–2: PC_Write=0, IF_ID/ID_EX/EX_MEM=01, MEM_WB=10; Stall_Count=3.
  - Cycle 3: all 00, state returns to RUN.
- Timeout: MEM_TIMEOUT=4, Mem_Ready held low → exactly 4 frozen cycles; 5th cycle released with Mem_Timeout=1, which stays 1 until reset.
- Reset mid-wait: pull reset low during MEM_WAIT → outputs immediately PC_Write=0 and all Ctrl=10; counters and Mem_Timeout become 0; state is RUN after deassert.
- Saturation: 65540 consecutive load-use stalls → Stall_Count=16'hFFFF, with no wrap. Cnt_Clear → 0 on the next cycle.
